spi_cmd_controller: RTL and testbench

//  Command-frame sequencer behind the SPI slave byte engine. Decodes each SSEL-bounded frame as

---
 rtl/spi_ctrl_pkg.sv | 22 ++
 rtl/spi_ctrl_regfile.sv | 40 ++++
 rtl/spi_cmd_controller.sv | 141 ++++++++++++++
 tb/tb_spi_cmd_controller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// rtl/spi_ctrl_pkg.sv - opcodes, FSM state type and status-byte helper for the SPI command controller
package spi_ctrl_pkg;

  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_STATUS = 8'h05;

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    RADDR,
    WDATA,
    RDATA,
    STAT,
    DISCARD
  } ctrl_state_t;

  function automatic logic [7:0] status_byte(input logic err, input logic [3:0] cnt);
    return {err, 3'b000, cnt};
  endfunction

endpackage

// File: rtl/spi_ctrl_regfile.sv
// rtl/spi_ctrl_regfile.sv - DEPTH x 8 register file, one write port, combinational read port
// Out-of-range addresses read as zero and never write.
module spi_ctrl_regfile
  import spi_ctrl_pkg::*;
#(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [7:0]           waddr,
  input  logic [7:0]           wdata,
  input  logic [7:0]           raddr,
  output logic [7:0]           rdata,
  output logic [8*DEPTH-1:0]   q
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
    end else if (we && (int'(waddr) < DEPTH)) begin
      mem_q[waddr[AW-1:0]] <= wdata;
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (int'(raddr) < DEPTH) rdata = mem_q[raddr[AW-1:0]];
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign q[8*g +: 8] = mem_q[g];
  end

endmodule

// File: rtl/spi_cmd_controller.sv
// rtl/spi_cmd_controller.sv - SSEL-framed opcode/address/data sequencer driving a register file
// Supplies the next MISO byte through tx_data one clock after each received byte.
module spi_cmd_controller
  import spi_ctrl_pkg::*;
#(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ssel_active,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic [7:0]           tx_data,
  output logic [8*DEPTH-1:0]   regs_out,
  output logic                 wr_strobe,
  output logic                 busy
);

  ctrl_state_t state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  tx_q, tx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        armed_q, armed_d;
  logic        wstb_q, wstb_d;

  logic        we;
  logic [7:0]  raddr, rdata, addr_inc;
  logic        byte_ok;

  function automatic logic in_range(input logic [7:0] a);
    return int'(a) < DEPTH;
  endfunction

  spi_ctrl_regfile #(.DEPTH(DEPTH), .RESET_VAL(RESET_VAL)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (addr_q),
    .wdata (rx_data),
    .raddr (raddr),
    .rdata (rdata),
    .q     (regs_out)
  );

  // In-range addresses wrap at DEPTH-1; out-of-range ones run on and wrap at 255.
  assign addr_inc = (int'(addr_q) == DEPTH - 1) ? 8'h00 : addr_q + 8'd1;
  // armed_q blocks bytes after a reset until the master has deselected once.
  assign byte_ok  = rx_valid && ssel_active && !armed_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tx_d    = tx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    armed_d = armed_q;
    wstb_d  = 1'b0;
    we      = 1'b0;
    raddr   = addr_inc;

    if (!ssel_active) begin
      armed_d = 1'b0;
      state_d = IDLE;
      tx_d    = 8'h00;
      if (state_q != IDLE) begin
        cnt_d = cnt_q + 4'd1;
        if (state_q == STAT) err_d = 1'b0;
      end
    end else if (byte_ok) begin
      unique case (state_q)
        IDLE: begin
          unique case (rx_data)
            OP_WRITE:  state_d = WADDR;
            OP_READ:   state_d = RADDR;
            OP_STATUS: begin
              state_d = STAT;
              tx_d    = status_byte(err_q, cnt_q);
            end
            default: begin
              state_d = DISCARD;
              err_d   = 1'b1;
            end
          endcase
        end
        WADDR: begin
          addr_d  = rx_data;
          state_d = WDATA;
        end
        RADDR: begin
          addr_d  = rx_data;
          raddr   = rx_data;
          tx_d    = rdata;
          state_d = RDATA;
          if (!in_range(rx_data)) err_d = 1'b1;
        end
        WDATA: begin
          addr_d = addr_inc;
          if (in_range(addr_q)) begin
            we     = 1'b1;
            wstb_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        RDATA: begin
          addr_d = addr_inc;
          tx_d   = rdata;
          if (!in_range(addr_inc)) err_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 8'h00;
      tx_q    <= 8'h00;
      cnt_q   <= 4'h0;
      err_q   <= 1'b0;
      armed_q <= 1'b1;
      wstb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      armed_q <= armed_d;
      wstb_q  <= wstb_d;
    end
  end

  assign tx_data   = tx_q;
  assign wr_strobe = wstb_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_cmd_controller.sv
// tb/tb_spi_cmd_controller.sv - directed and randomized frame bench for spi_cmd_controller
module tb_spi_cmd_controller;

  localparam int         DEPTH = 16;
  localparam logic [7:0] RV    = 8'h3C;

  logic                clk = 1'b0;
  logic                rst, ssel, rxv, wstb, busy;
  logic [7:0]          rxd, txd;
  logic [8*DEPTH-1:0]  regs;

  always #5 clk = ~clk;

  spi_cmd_controller #(.DEPTH(DEPTH), .RESET_VAL(RV)) dut (
    .clk         (clk),
    .rst         (rst),
    .ssel_active (ssel),
    .rx_valid    (rxv),
    .rx_data     (rxd),
    .tx_data     (txd),
    .regs_out    (regs),
    .wr_strobe   (wstb),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;

  // Frame-level reference: register array, sticky error, frame count, bytes of the current frame.
  logic [7:0] m_regs [DEPTH];
  bit         m_err;
  logic [3:0] m_cnt;
  bit         m_blocked;
  logic [7:0] m_stat;
  logic [7:0] fb [$];

  function automatic int nxt(int a);
    return (a == DEPTH - 1) ? 0 : (a + 1) % 256;
  endfunction

  function automatic int addr_at(int base, int k);
    int a = base;
    for (int j = 0; j < k; j++) a = nxt(a);
    return a;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(string tag);
    for (int i = 0; i < DEPTH; i++)
      chk($sformatf("%s_reg%0d", tag, i), {24'h0, regs[8*i +: 8]}, {24'h0, m_regs[i]});
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_regs[i] = RV;
    m_err = 0; m_cnt = 0; m_blocked = 1; fb.delete();
  endtask

  task automatic send(logic [7:0] b);
    int i, a;
    logic [7:0] op, exp_tx;
    bit exp_w;
    exp_tx = 8'h00; exp_w = 0;
    @(negedge clk); rxv = 1'b1; rxd = b;
    @(negedge clk); rxv = 1'b0; rxd = 8'($urandom);
    if (!m_blocked) begin
      fb.push_back(b);
      i  = fb.size() - 1;
      op = fb[0];
      if (i == 0) begin
        if (op == 8'h05) m_stat = {m_err, 3'b000, m_cnt};
        else if (op != 8'h02 && op != 8'h03) m_err = 1;
      end
      case (op)
        8'h05: exp_tx = m_stat;
        8'h03: if (i >= 1) begin
          a = addr_at(int'(fb[1]), i - 1);
          if (a < DEPTH) exp_tx = m_regs[a];
          else m_err = 1;
        end
        8'h02: if (i >= 2) begin
          a = addr_at(int'(fb[1]), i - 2);
          if (a < DEPTH) begin m_regs[a] = b; exp_w = 1; end
          else m_err = 1;
        end
        default: ;
      endcase
    end
    chk("wr_strobe", {31'h0, wstb}, {31'h0, exp_w});
    chk("tx_data", {24'h0, txd}, {24'h0, exp_tx});
    chk("busy", {31'h0, busy}, {31'h0, !m_blocked});
    repeat (2) @(negedge clk);
    chk("tx_hold", {24'h0, txd}, {24'h0, exp_tx});
    chk("wr_strobe_pulse", {31'h0, wstb}, 32'h0);
  endtask

  task automatic model_end();
    if (!m_blocked && fb.size() > 0) begin
      m_cnt = m_cnt + 4'd1;
      if (fb[0] == 8'h05) m_err = 0;
    end
    fb.delete();
    m_blocked = 0;
  endtask

  task automatic start_frame();
    @(negedge clk); ssel = 1'b1;
    @(negedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk); ssel = 1'b0;
    model_end();
    @(negedge clk);
    chk("end_busy", {31'h0, busy}, 32'h0);
    chk("end_tx", {24'h0, txd}, 32'h0);
    chk_regs("end");
  endtask

  task automatic frame(input logic [7:0] q[$]);
    start_frame();
    foreach (q[k]) send(q[k]);
    end_frame();
  endtask

  initial begin
    logic [7:0] q [$];
    logic [7:0] op;
    int n;
    rst = 1'b1; ssel = 1'b0; rxv = 1'b0; rxd = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_tx", {24'h0, txd}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_wstb", {31'h0, wstb}, 32'h0);
    chk_regs("rst");
    rst = 1'b0;
    @(negedge clk);
    model_end();

    frame('{8'h02, 8'h03, 8'hAA, 8'hBB});
    chk("t1_reg3", {24'h0, regs[8*3 +: 8]}, 32'hAA);
    chk("t1_reg4", {24'h0, regs[8*4 +: 8]}, 32'hBB);
    frame('{8'h03, 8'h03, 8'($urandom), 8'($urandom)});
    frame('{8'h02, 8'h0F, 8'h11, 8'h22});
    chk("t3_reg15", {24'h0, regs[8*15 +: 8]}, 32'h11);
    chk("t3_reg0", {24'h0, regs[8*0 +: 8]}, 32'h22);
    frame('{8'h05, 8'h00});
    frame('{8'h03, 8'h20, 8'h00});
    frame('{8'h05, 8'h00});
    frame('{8'h05, 8'h00});
    frame('{8'h7E, 8'h02, 8'h05, 8'h99});
    frame('{8'h03, 8'hFE, 8'h00, 8'h00, 8'h00});
    start_frame(); end_frame();
    frame('{8'h05});

    // Deselect coinciding with a data byte: the byte must be dropped.
    start_frame();
    send(8'h02); send(8'h05);
    @(negedge clk); ssel = 1'b0; rxv = 1'b1; rxd = 8'h99;
    model_end();
    @(negedge clk); rxv = 1'b0;
    chk("abort_wstb", {31'h0, wstb}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk_regs("abort");

    // Reset in the middle of a write burst, with SSEL still asserted.
    start_frame();
    send(8'h02); send(8'h01); send(8'h77);
    @(negedge clk); rst = 1'b1;
    model_reset();
    @(negedge clk); rst = 1'b0;
    chk("mrst_busy", {31'h0, busy}, 32'h0);
    chk("mrst_tx", {24'h0, txd}, 32'h0);
    chk_regs("mrst");
    send(8'h02); send(8'h00); send(8'h5A);
    end_frame();
    frame('{8'h02, 8'h00, 8'h5A});
    chk("t6_reg0", {24'h0, regs[7:0]}, 32'h5A);
    frame('{8'h05, 8'h00});

    for (int f = 0; f < 40; f++) begin
      q.delete();
      case ($urandom_range(0, 3))
        0: op = 8'h02;
        1: op = 8'h03;
        2: op = 8'h05;
        default: op = 8'($urandom);
      endcase
      n = $urandom_range(0, 5);
      if (n > 0) q.push_back(op);
      if (n > 1) q.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, DEPTH - 1)));
      for (int k = 2; k < n; k++) q.push_back(8'($urandom));
      frame(q);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
